// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder:
// register offsets, STATUS bit layout, default window base.
package mmio_pkg;

  localparam logic [31:0] DEF_BASE = 32'hFFFF_FFE0;

  localparam logic [2:0] OFF_LED     = 3'd0;
  localparam logic [2:0] OFF_TXDATA  = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_STATCLR = 3'd3;
  localparam logic [2:0] OFF_CYCLE   = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int CNT_LSB   = 4;
  localparam int OVF_BIT   = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push into a full FIFO is taken
// only when a pop frees the slot in the same cycle.
// Ports: clk, reset, push, pop, din, dout (0 when
// empty), empty, full, count (0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, wptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates dout.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_resp.sv
// MMIO responder: LED/scratch/cycle/status regs and a
// TX FIFO drained over a valid/ready bus.
// Ports: clk, reset, we, addr, d_in, d_out, sel, leds,
// bus, bus_valid, bus_ready.
module mmio_resp
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEF_BASE,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        sel,
  output logic [7:0]  leds,
  output logic [31:0] bus,
  output logic        bus_valid,
  input  logic        bus_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       off;
  logic             wr, push, pop;
  logic             f_empty, f_full;
  logic [CW-1:0]    f_count;
  logic [31:0]      status;
  logic             ovf_set, ovf_clr;
  logic             unused_addr;

  logic [7:0]       leds_q, leds_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             ovf_q, ovf_d;

  assign off  = addr[4:2];
  assign sel  = (addr[31:5] == BASE_ADDR[31:5]);
  assign wr   = we & sel;
  assign push = wr && (off == OFF_TXDATA);
  assign pop  = bus_valid & bus_ready;

  assign unused_addr = ^addr[1:0];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (d_in),
    .dout  (bus),
    .empty (f_empty),
    .full  (f_full),
    .count (f_count)
  );

  assign bus_valid = ~f_empty;
  assign leds      = leds_q;

  // A pop frees the slot, so only push-without-pop overflows.
  assign ovf_set = push & f_full & ~pop;
  assign ovf_clr = wr && (off == OFF_STATCLR) && d_in[OVF_BIT];

  always_comb begin
    status                  = '0;
    status[EMPTY_BIT]       = f_empty;
    status[FULL_BIT]        = f_full;
    status[CNT_LSB +: 8]    = 8'(f_count);
    status[OVF_BIT]         = ovf_q;
  end

  always_comb begin
    d_out = '0;
    if (sel) begin
      case (off)
        OFF_LED:     d_out = {24'd0, leds_q};
        OFF_STATUS:  d_out = status;
        OFF_CYCLE:   d_out = 32'(cyc_q);
        OFF_SCRATCH: d_out = scratch_q;
        default:     d_out = '0;
      endcase
    end
  end

  always_comb begin
    leds_d    = leds_q;
    scratch_d = scratch_q;
    cyc_d     = cyc_q + 1'b1;
    ovf_d     = ovf_set | (ovf_q & ~ovf_clr);
    if (wr) begin
      case (off)
        OFF_LED:     leds_d    = d_in[7:0];
        OFF_CYCLE:   cyc_d     = d_in[CNT_W-1:0];
        OFF_SCRATCH: scratch_d = d_in;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q    <= '0;
      scratch_q <= '0;
      cyc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      leds_q    <= leds_d;
      scratch_q <= scratch_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_resp.sv
// Scoreboard bench for mmio_resp: directed register
// accesses plus a monitor checking the drained bus words.
module tb_mmio_resp;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFE0;

  logic        clk = 1'b0;
  logic        reset, we, sel, bus_valid, bus_ready;
  logic [31:0] addr, d_in, d_out, bus;
  logic [7:0]  leds;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  mmio_resp dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .d_in      (d_in),
    .d_out     (d_out),
    .sel       (sel),
    .leds      (leds),
    .bus       (bus),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ra(input logic [2:0] o);
    return BASE | {27'd0, o, 2'b00};
  endfunction

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    d_in = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    wr_a(ra(o), d);
  endtask

  task automatic rd(input logic [2:0] o, input logic [31:0] exp,
                    input string nm);
    we   = 1'b0;
    addr = ra(o);
    #1;
    chk(nm, d_out, exp);
  endtask

  task automatic push_w(input logic [31:0] d, input bit kept);
    if (kept) sb.push_back(d);
    wr(OFF_TXDATA, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus_ready = 1'b1;
    while (bus_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus_ready = 1'b0;
    chk("drain_done", {31'd0, bus_valid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  // Monitor: each accepted bus word must be the oldest expected.
  always @(negedge clk) begin
    if (!reset && bus_valid && bus_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_extra: got %h want none", bus);
      end else begin
        chk("bus_word", bus, sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    we = 1'b0;
    addr = '0;
    d_in = '0;
    bus_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state and counter start
    rd(OFF_STATUS, 32'h1, "rst_status");
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_valid", {31'd0, bus_valid}, 32'h0);
    chk("rst_bus", bus, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd(OFF_CYCLE, 32'd3, "cycle_3");

    // 2: LED, scratch, out-of-window write
    wr(OFF_LED, 32'h1A5);
    chk("leds_a5", {24'd0, leds}, 32'hA5);
    rd(OFF_LED, 32'hA5, "led_rd");
    wr(OFF_SCRATCH, 32'hDEADBEEF);
    rd(OFF_SCRATCH, 32'hDEADBEEF, "scratch_rd");
    addr = BASE - 32'd4;
    d_in = 32'h55;
    we   = 1'b1;
    #1;
    chk("sel_out", {31'd0, sel}, 32'h0);
    chk("dout_out", d_out, 32'h0);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("leds_keep", {24'd0, leds}, 32'hA5);
    rd(OFF_SCRATCH, 32'hDEADBEEF, "scratch_keep");
    rd(OFF_TXDATA, 32'h0, "txdata_rd0");

    // 3: three words, then drain one per cycle
    push_w(32'h11, 1);
    push_w(32'h22, 1);
    push_w(32'h33, 1);
    rd(OFF_STATUS, 32'h30, "status_3");
    chk("bus_head", bus, 32'h11);
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bus_22", bus, 32'h22);
    @(posedge clk);
    #1;
    chk("bus_33", bus, 32'h33);
    @(posedge clk);
    #1;
    bus_ready = 1'b0;
    chk("drained_valid", {31'd0, bus_valid}, 32'h0);
    chk("drained_bus", bus, 32'h0);
    rd(OFF_STATUS, 32'h1, "status_empty");

    // 4: overflow, no-op clear, real clear
    for (int i = 0; i < 9; i++) push_w(32'h100 + i, i < 8);
    rd(OFF_STATUS, 32'h0001_0082, "status_ovf");
    wr(OFF_STATCLR, 32'h0);
    rd(OFF_STATUS, 32'h0001_0082, "clr_noop");
    wr(OFF_STATCLR, 32'h1_0000);
    rd(OFF_STATUS, 32'h82, "clr_ovf");
    drain();
    rd(OFF_STATUS, 32'h1, "status_after4");

    // 5: push+pop while full, push+ready while empty
    for (int i = 0; i < 8; i++) push_w(32'h200 + i, 1);
    bus_ready = 1'b1;
    push_w(32'h99, 1);
    bus_ready = 1'b0;
    rd(OFF_STATUS, 32'h82, "full_pushpop");
    drain();
    bus_ready = 1'b1;
    push_w(32'h77, 1);
    chk("empty_push_valid", {31'd0, bus_valid}, 32'h1);
    chk("empty_push_bus", bus, 32'h77);
    @(posedge clk);
    #1;
    bus_ready = 1'b0;
    chk("empty_push_gone", {31'd0, bus_valid}, 32'h0);
    chk("sb_empty5", sb.size(), 32'd0);

    // 6: counter wrap, reset mid-queue
    wr(OFF_CYCLE, 32'hFFFF_FFFE);
    rd(OFF_CYCLE, 32'hFFFF_FFFE, "cyc_load");
    @(posedge clk);
    #1;
    rd(OFF_CYCLE, 32'hFFFF_FFFF, "cyc_max");
    @(posedge clk);
    #1;
    rd(OFF_CYCLE, 32'h0, "cyc_wrap");
    for (int i = 0; i < 4; i++) push_w(32'h300 + i, 1);
    rd(OFF_STATUS, 32'h40, "status_4q");
    reset = 1'b1;
    sb.delete();
    bus_ready = 1'b1;
    addr = ra(OFF_LED);
    d_in = 32'hFF;
    we = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    we = 1'b0;
    bus_ready = 1'b0;
    chk("rst2_valid", {31'd0, bus_valid}, 32'h0);
    chk("rst2_bus", bus, 32'h0);
    chk("rst2_leds", {24'd0, leds}, 32'h0);
    rd(OFF_STATUS, 32'h1, "rst2_status");
    rd(OFF_SCRATCH, 32'h0, "rst2_scratch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
